// File: rtl/rs_issue_queue.sv
// rs_issue_queue: age-ordered compacting reservation station with dual-CDB wakeup.
// Index 0 holds the oldest entry; the lowest-index entry with both operands ready issues.
module rs_issue_queue #(
  parameter int RS_SIZE   = 8,
  parameter int DATA_SIZE = 32,
  parameter int TAG_W     = 32,
  parameter int CTRL_W    = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_alloc_valid,
  output logic                       o_alloc_ready,
  input  logic [TAG_W-1:0]           i_alloc_tag,
  input  logic [CTRL_W-1:0]          i_alloc_ctrl,
  input  logic [DATA_SIZE-1:0]       i_alloc_value_1,
  input  logic [DATA_SIZE-1:0]       i_alloc_value_2,
  input  logic [TAG_W-1:0]           i_alloc_tag_1,
  input  logic [TAG_W-1:0]           i_alloc_tag_2,
  input  logic [DATA_SIZE-1:0]       i_alloc_imm,
  input  logic [TAG_W-1:0]           i_cdb_tag_1,
  input  logic [DATA_SIZE-1:0]       i_cdb_value_1,
  input  logic [TAG_W-1:0]           i_cdb_tag_2,
  input  logic [DATA_SIZE-1:0]       i_cdb_value_2,
  output logic                       o_issue_valid,
  input  logic                       i_issue_ready,
  output logic [TAG_W-1:0]           o_issue_tag,
  output logic [CTRL_W-1:0]          o_issue_ctrl,
  output logic [DATA_SIZE-1:0]       o_issue_value_1,
  output logic [DATA_SIZE-1:0]       o_issue_value_2,
  output logic [DATA_SIZE-1:0]       o_issue_imm,
  output logic [$clog2(RS_SIZE):0]   o_count
);
  localparam int CW = $clog2(RS_SIZE) + 1;
  localparam int IW = $clog2(RS_SIZE);
  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [CTRL_W-1:0]    ctrl;
    logic [TAG_W-1:0]     t1;
    logic [TAG_W-1:0]     t2;
    logic [DATA_SIZE-1:0] v1;
    logic [DATA_SIZE-1:0] v2;
    logic [DATA_SIZE-1:0] imm;
  } entry_t;
  entry_t        r_q [RS_SIZE];
  entry_t        w_nq [RS_SIZE];
  entry_t        w_new;
  entry_t        w_out;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [IW-1:0] w_sel;
  logic          w_any;
  logic          w_issue;
  logic          w_alloc;
  // CDB 1 wins when both broadcasts carry the awaited tag; a zero tag never matches.
  function automatic entry_t snoop(input entry_t e, input logic [TAG_W-1:0] ct1, ct2,
                                   input logic [DATA_SIZE-1:0] cv1, cv2);
    entry_t r;
    r = e;
    if (r.t1 != '0 && r.t1 == ct1) begin
      r.v1 = cv1;
      r.t1 = '0;
    end else if (r.t1 != '0 && r.t1 == ct2) begin
      r.v1 = cv2;
      r.t1 = '0;
    end
    if (r.t2 != '0 && r.t2 == ct1) begin
      r.v2 = cv1;
      r.t2 = '0;
    end else if (r.t2 != '0 && r.t2 == ct2) begin
      r.v2 = cv2;
      r.t2 = '0;
    end
    return r;
  endfunction
  assign w_new = '{i_alloc_tag, i_alloc_ctrl, i_alloc_tag_1, i_alloc_tag_2,
                   i_alloc_value_1, i_alloc_value_2, i_alloc_imm};
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (CW'(i) < r_count && r_q[i].t1 == '0 && r_q[i].t2 == '0) begin
        w_any = 1'b1;
        w_sel = IW'(i);
      end
  end
  assign o_alloc_ready = r_count != CW'(RS_SIZE);
  assign o_issue_valid = w_any && !i_flush;
  assign w_issue       = o_issue_valid && i_issue_ready;
  assign w_alloc       = i_alloc_valid && o_alloc_ready && !i_flush;
  assign w_out         = o_issue_valid ? r_q[w_sel] : '0;
  assign o_issue_tag     = w_out.tag;
  assign o_issue_ctrl    = w_out.ctrl;
  assign o_issue_value_1 = w_out.v1;
  assign o_issue_value_2 = w_out.v2;
  assign o_issue_imm     = w_out.imm;
  assign o_count         = r_count;
  // Shift above the issued slot, wake the shifted entries, then append at the new tail.
  always_comb begin
    entry_t e;
    w_count_nxt = i_flush ? '0 : r_count + CW'(w_alloc) - CW'(w_issue);
    for (int i = 0; i < RS_SIZE; i++) begin
      e = (w_issue && IW'(i) >= w_sel) ? r_q[(i + 1) % RS_SIZE] : r_q[i];
      e = snoop(e, i_cdb_tag_1, i_cdb_tag_2, i_cdb_value_1, i_cdb_value_2);
      if (w_alloc && CW'(i) == r_count - CW'(w_issue))
        e = snoop(w_new, i_cdb_tag_1, i_cdb_tag_2, i_cdb_value_1, i_cdb_value_2);
      w_nq[i] = CW'(i) >= w_count_nxt ? '0 : e;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_q     <= '{default: '0};
      r_count <= '0;
    end else begin
      r_q     <= w_nq;
      r_count <= w_count_nxt;
    end
  always_ff @(posedge i_clk)
    if (!i_reset)
      assert (!(i_alloc_valid && !o_alloc_ready))
      else $warning("rs_issue_queue: alloc_valid while full is ignored");
endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed checks of reset, issue, wakeup, ordering, full and flush behaviour.
module tb_rs_issue_queue;
  logic        clk, reset, flush, alloc_valid, alloc_ready, issue_valid, issue_ready;
  logic [31:0] alloc_tag, alloc_ctrl, alloc_value_1, alloc_value_2, alloc_tag_1, alloc_tag_2, alloc_imm;
  logic [31:0] cdb_tag_1, cdb_value_1, cdb_tag_2, cdb_value_2;
  logic [31:0] issue_tag, issue_ctrl, issue_value_1, issue_value_2, issue_imm;
  logic [3:0]  count;
  int          npass = 0;
  int          ntotal = 0;

  rs_issue_queue dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_alloc_valid(alloc_valid), .o_alloc_ready(alloc_ready),
    .i_alloc_tag(alloc_tag), .i_alloc_ctrl(alloc_ctrl),
    .i_alloc_value_1(alloc_value_1), .i_alloc_value_2(alloc_value_2),
    .i_alloc_tag_1(alloc_tag_1), .i_alloc_tag_2(alloc_tag_2), .i_alloc_imm(alloc_imm),
    .i_cdb_tag_1(cdb_tag_1), .i_cdb_value_1(cdb_value_1),
    .i_cdb_tag_2(cdb_tag_2), .i_cdb_value_2(cdb_value_2),
    .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
    .o_issue_tag(issue_tag), .o_issue_ctrl(issue_ctrl),
    .o_issue_value_1(issue_value_1), .o_issue_value_2(issue_value_2),
    .o_issue_imm(issue_imm), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
  endtask

  task automatic put(input logic [31:0] tag, t1, t2, v1, v2);
    alloc_valid   = 1'b1;
    alloc_tag     = tag;
    alloc_tag_1   = t1;
    alloc_tag_2   = t2;
    alloc_value_1 = v1;
    alloc_value_2 = v2;
    alloc_ctrl    = tag + 100;
    alloc_imm     = tag + 200;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    alloc_valid = 1'b0; alloc_tag = '0; alloc_ctrl = '0; alloc_value_1 = '0; alloc_value_2 = '0;
    alloc_tag_1 = '0; alloc_tag_2 = '0; alloc_imm = '0;
    cdb_tag_1 = '0; cdb_value_1 = '0; cdb_tag_2 = '0; cdb_value_2 = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_tag", issue_tag, 0);
    // ready-at-alloc entry, plus an insert that lands at count-1 during an issue
    put(3, 0, 0, 5, 7);
    issue_ready = 1'b1;
    #1 chk("t2_no_passthrough", issue_valid, 0);
    @(negedge clk);
    put(30, 0, 0, 9, 0);
    #1;
    chk("t2_valid", issue_valid, 1);
    chk("t2_tag", issue_tag, 3);
    chk("t2_v1", issue_value_1, 5);
    chk("t2_v2", issue_value_2, 7);
    chk("t2_ctrl", issue_ctrl, 103);
    chk("t2_imm", issue_imm, 203);
    chk("t2_count1", count, 1);
    @(negedge clk);
    alloc_valid = 1'b0;
    #1;
    chk("t2_ins_count", count, 1);
    chk("t2_ins_tag", issue_tag, 30);
    chk("t2_ins_v1", issue_value_1, 9);
    @(negedge clk); #1;
    chk("t2_count0", count, 0);
    chk("t2_empty_valid", issue_valid, 0);
    // CDB1 wakeup of operand 1
    put(4, 2, 0, 0, 8);
    @(negedge clk);
    alloc_valid = 1'b0; cdb_tag_1 = 2; cdb_value_1 = 32'h55;
    #1 chk("t3_waiting", issue_valid, 0);
    @(negedge clk);
    cdb_tag_1 = 0;
    #1;
    chk("t3_valid", issue_valid, 1);
    chk("t3_tag", issue_tag, 4);
    chk("t3_v1", issue_value_1, 32'h55);
    chk("t3_v2", issue_value_2, 8);
    @(negedge clk); #1;
    chk("t3_count0", count, 0);
    // fill with waiting entries
    issue_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      put(k, 100 + k, 0, k, 0);
      @(negedge clk);
    end
    put(9, 0, 0, 0, 0);
    #1;
    chk("t4_full_ready", alloc_ready, 0);
    chk("t4_full_count", count, 8);
    @(negedge clk);
    alloc_valid = 1'b0;
    #1;
    chk("t4_ignored_count", count, 8);
    chk("t4_none_ready", issue_valid, 0);
    cdb_tag_2 = 106; cdb_value_2 = 32'h66;
    @(negedge clk);
    cdb_tag_2 = 0;
    #1;
    chk("t4_valid", issue_valid, 1);
    chk("t4_tag6", issue_tag, 6);
    chk("t4_v1", issue_value_1, 32'h66);
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    #1;
    chk("t4_count7", count, 7);
    chk("t4_alloc_ready", alloc_ready, 1);
    chk("t4_after_valid", issue_valid, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("t4_flush_count", count, 0);
    // age order, stall stability, and wakeup of a shifting entry
    put(10, 0, 0, 1, 0);
    @(negedge clk);
    put(11, 0, 0, 2, 0);
    @(negedge clk);
    put(12, 50, 0, 0, 0);
    @(negedge clk);
    alloc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t5_hold_tag", issue_tag, 10);
      @(negedge clk);
    end
    issue_ready = 1'b1; cdb_tag_1 = 50; cdb_value_1 = 32'h77;
    #1 chk("t5_a_tag", issue_tag, 10);
    @(negedge clk);
    cdb_tag_1 = 0;
    #1;
    chk("t5_b_tag", issue_tag, 11);
    chk("t5_b_count", count, 2);
    @(negedge clk); #1;
    chk("t5_c_tag", issue_tag, 12);
    chk("t5_c_v1", issue_value_1, 32'h77);
    chk("t5_c_count", count, 1);
    @(negedge clk); #1;
    chk("t5_count0", count, 0);
    chk("t5_valid0", issue_valid, 0);
    issue_ready = 1'b0;
    // insert-time snoop with CDB1 priority, then flush dropping alloc and issue
    put(20, 0, 6, 3, 0);
    cdb_tag_1 = 6; cdb_value_1 = 1; cdb_tag_2 = 6; cdb_value_2 = 9;
    @(negedge clk);
    alloc_valid = 1'b0; cdb_tag_1 = 0; cdb_tag_2 = 0;
    #1;
    chk("t6_valid", issue_valid, 1);
    chk("t6_tag", issue_tag, 20);
    chk("t6_v2_cdb1", issue_value_2, 1);
    chk("t6_v1", issue_value_1, 3);
    put(21, 0, 0, 0, 0);
    @(negedge clk);
    put(22, 0, 0, 0, 0);
    @(negedge clk);
    alloc_valid = 1'b0;
    #1 chk("t6_count3", count, 3);
    flush = 1'b1; issue_ready = 1'b1;
    put(23, 0, 0, 0, 0);
    #1 chk("t6_flush_gates_valid", issue_valid, 0);
    @(negedge clk);
    flush = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0;
    #1;
    chk("t6_flush_count", count, 0);
    chk("t6_flush_valid", issue_valid, 0);
    chk("t6_flush_alloc_ready", alloc_ready, 1);
    // asynchronous reset between clock edges
    put(40, 0, 0, 0, 0);
    @(negedge clk);
    alloc_valid = 1'b0;
    #1 chk("t7_pre_count", count, 1);
    reset = 1'b1;
    #1;
    chk("t7_async_count", count, 0);
    chk("t7_async_valid", issue_valid, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("t7_post_count", count, 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
